// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU request arbiter.
// Contents: default datapath width, ALU opcode values, FSM state encoding,
//           and the opcode legality helper used when ALU_ARB_OPCODE_CHECK_EN is defined.
package alu_arb_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Legal opcodes are the contiguous range OP_ADD..OP_SRA.
  function automatic logic op_is_legal(input logic [4:0] op);
    return (op <= OP_SRA);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
// Ports: i_req_valid (per-requester valid), i_ptr (requester favoured on a tie),
//        o_grant (one-hot grant, 2'b00 when nobody requests).
module rr_arb2 (
  input  logic [1:0] i_req_valid,
  input  logic       i_ptr,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between two requesters, one operation at a time,
//   round-robin grant, fixed ALU_LATENCY wait, result returned over a valid/ready channel.
// Ports: i_clock/i_reset (async, active-high); i_req_* / o_req_ready requester side;
//   o_rsp_* / i_rsp_ready response side; o_alu_* / i_alu_* ALU side.
// Optional: define ALU_ARB_OPCODE_CHECK_EN to reject opcodes above SRA with o_rsp_err.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ALU_LATENCY = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  input  logic [9:0]         i_req_opcode,
  input  logic [9:0]         i_req_shamt,
  input  logic [2*WIDTH-1:0] i_req_a,
  input  logic [2*WIDTH-1:0] i_req_b,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_id,
  output logic [WIDTH-1:0]   o_rsp_result,
  output logic               o_rsp_ne,
  output logic               o_rsp_lt,
  output logic               o_rsp_ovf,
  output logic               o_rsp_err,
  output logic [4:0]         o_alu_opcode,
  output logic [4:0]         o_alu_shamt,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  input  logic [WIDTH-1:0]   i_alu_result,
  input  logic               i_alu_ne,
  input  logic               i_alu_lt,
  input  logic               i_alu_ovf
);

  localparam int CW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAT_INIT = CW'(ALU_LATENCY);

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_id;
  logic [CW-1:0]    r_cnt;
  logic [4:0]       r_alu_opcode;
  logic [4:0]       r_alu_shamt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_ne;
  logic             r_rsp_lt;
  logic             r_rsp_ovf;

  logic [1:0]       w_grant;
  logic             w_gid;
  logic             w_xfer;
  logic             w_legal;
  logic [4:0]       w_sel_op;
  logic [4:0]       w_sel_sh;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;

  rr_arb2 u_rr_arb2 (
    .i_req_valid (i_req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant)
  );

  assign w_gid    = w_grant[1];
  assign w_xfer   = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_sel_op = w_gid ? i_req_opcode[9:5] : i_req_opcode[4:0];
  assign w_sel_sh = w_gid ? i_req_shamt[9:5]  : i_req_shamt[4:0];
  assign w_sel_a  = w_gid ? i_req_a[2*WIDTH-1:WIDTH] : i_req_a[WIDTH-1:0];
  assign w_sel_b  = w_gid ? i_req_b[2*WIDTH-1:WIDTH] : i_req_b[WIDTH-1:0];

`ifdef ALU_ARB_OPCODE_CHECK_EN
  logic r_rsp_err;
  assign w_legal   = op_is_legal(w_sel_op);
  assign o_rsp_err = r_rsp_err;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rsp_err <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_err <= ~w_legal;
    end
  end
`else
  assign w_legal   = 1'b1;
  assign o_rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; an illegal opcode bypasses EXEC so the ALU never sees it
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_next = w_legal ? EXEC : RESP;
      EXEC:    if (r_cnt == '0) w_next = RESP;
      RESP:    if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs; ready is masked during reset so nothing looks accepted
  always_comb begin
    o_req_ready = 2'b00;
    o_rsp_valid = 1'b0;
    case (r_state)
      IDLE:    o_req_ready = i_reset ? 2'b00 : w_grant;
      RESP:    o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch (held outside EXEC), latency counter, response capture
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ptr        <= 1'b0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_alu_opcode <= '0;
      r_alu_shamt  <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_result <= '0;
      r_rsp_ne     <= 1'b0;
      r_rsp_lt     <= 1'b0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_id  <= w_gid;
        r_ptr <= ~w_gid;
        if (w_legal) begin
          r_alu_opcode <= w_sel_op;
          r_alu_shamt  <= w_sel_sh;
          r_alu_a      <= w_sel_a;
          r_alu_b      <= w_sel_b;
          r_cnt        <= LAT_INIT;
        end else begin
          r_rsp_result <= '0;
          r_rsp_ne     <= 1'b0;
          r_rsp_lt     <= 1'b0;
          r_rsp_ovf    <= 1'b0;
        end
      end
      if (r_state == EXEC) begin
        if (r_cnt == '0) begin
          r_rsp_result <= i_alu_result;
          r_rsp_ne     <= i_alu_ne;
          r_rsp_lt     <= i_alu_lt;
          r_rsp_ovf    <= i_alu_ovf;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_rsp_id     = r_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_ne     = r_rsp_ne;
  assign o_rsp_lt     = r_rsp_lt;
  assign o_rsp_ovf    = r_rsp_ovf;
  assign o_alu_opcode = r_alu_opcode;
  assign o_alu_shamt  = r_alu_shamt;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed bench with a response scoreboard.
// A behavioural ALU sits on the ALU port; expected responses are queued at issue
// and popped by a monitor on every response handshake.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         ne;
    logic         lt;
    logic         ovf;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] res;
    logic         ne;
    logic         lt;
    logic         ovf;
  } alu_o_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t mon_e;

  // ALU_LATENCY = 0 instance
  logic [1:0]   req_valid, req_ready;
  logic [9:0]   req_op, req_sh;
  logic [63:0]  req_a, req_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_ne, rsp_lt, rsp_ovf, rsp_err;
  logic [W-1:0] rsp_result;
  logic [4:0]   alu_op, alu_sh;
  logic [W-1:0] alu_a, alu_b;
  alu_o_t       m0;

  // ALU_LATENCY = 3 instance
  logic [1:0]   req_valid3, req_ready3;
  logic [9:0]   req_op3, req_sh3;
  logic [63:0]  req_a3, req_b3;
  logic         rsp_valid3, rsp_ready3, rsp_id3, rsp_ne3, rsp_lt3, rsp_ovf3, rsp_err3;
  logic [W-1:0] rsp_result3;
  logic [4:0]   alu_op3, alu_sh3;
  logic [W-1:0] alu_a3, alu_b3;
  alu_o_t       m3;

  function automatic alu_o_t alu_model(input logic [4:0] op, input logic [4:0] sh,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    alu_o_t o;
    o.res = '0;
    o.ovf = 1'b0;
    case (op)
      OP_ADD: begin o.res = a + b; o.ovf = (a[W-1] == b[W-1]) && (o.res[W-1] != a[W-1]); end
      OP_SUB: begin o.res = a - b; o.ovf = (a[W-1] != b[W-1]) && (o.res[W-1] != a[W-1]); end
      OP_AND: o.res = a & b;
      OP_OR:  o.res = a | b;
      OP_SLL: o.res = a << sh;
      OP_SRA: o.res = $signed(a) >>> sh;
      default: o.res = '0;
    endcase
    o.ne = (a != b);
    o.lt = ($signed(a) < $signed(b));
    return o;
  endfunction

  always_comb m0 = alu_model(alu_op, alu_sh, alu_a, alu_b);
  always_comb m3 = alu_model(alu_op3, alu_sh3, alu_a3, alu_b3);

  alu_req_arbiter #(.WIDTH(W), .ALU_LATENCY(0)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_opcode(req_op), .i_req_shamt(req_sh), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_ne(rsp_ne), .o_rsp_lt(rsp_lt),
    .o_rsp_ovf(rsp_ovf), .o_rsp_err(rsp_err),
    .o_alu_opcode(alu_op), .o_alu_shamt(alu_sh), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .i_alu_result(m0.res), .i_alu_ne(m0.ne), .i_alu_lt(m0.lt), .i_alu_ovf(m0.ovf)
  );

  alu_req_arbiter #(.WIDTH(W), .ALU_LATENCY(3)) dut3 (
    .i_clock(clk), .i_reset(rst),
    .i_req_valid(req_valid3), .o_req_ready(req_ready3),
    .i_req_opcode(req_op3), .i_req_shamt(req_sh3), .i_req_a(req_a3), .i_req_b(req_b3),
    .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3), .o_rsp_id(rsp_id3),
    .o_rsp_result(rsp_result3), .o_rsp_ne(rsp_ne3), .o_rsp_lt(rsp_lt3),
    .o_rsp_ovf(rsp_ovf3), .o_rsp_err(rsp_err3),
    .o_alu_opcode(alu_op3), .o_alu_shamt(alu_sh3), .o_alu_a(alu_a3), .o_alu_b(alu_b3),
    .i_alu_result(m3.res), .i_alu_ne(m3.ne), .i_alu_lt(m3.lt), .i_alu_ovf(m3.ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every response handshake against the queue head
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d result 0x%0h, expected no response", rsp_id, rsp_result);
      end else begin
        mon_e = q.pop_front();
        check("rsp_id",     64'(rsp_id),     64'(mon_e.id));
        check("rsp_result", 64'(rsp_result), 64'(mon_e.res));
        check("rsp_ne",     64'(rsp_ne),     64'(mon_e.ne));
        check("rsp_lt",     64'(rsp_lt),     64'(mon_e.lt));
        check("rsp_ovf",    64'(rsp_ovf),    64'(mon_e.ovf));
        check("rsp_err",    64'(rsp_err),    64'(mon_e.err));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for any grant, checks it, records the accept cycle, then steps past the edge
  task automatic wait_ready(input logic [1:0] want, input string name, output int acc);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) break;
    end
    check(name, 64'(req_ready), 64'(want));
    acc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string name, input int acc, input int lat);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check(name, 64'(cyc - acc), 64'(lat));
  endtask

  task automatic set_lane(input int lane, input logic [4:0] op, input logic [4:0] sh,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    if (lane == 0) begin
      req_op[4:0] = op; req_sh[4:0] = sh; req_a[31:0] = a; req_b[31:0] = b;
    end else begin
      req_op[9:5] = op; req_sh[9:5] = sh; req_a[63:32] = a; req_b[63:32] = b;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int lat6;
    req_valid = '0; req_op = '0; req_sh = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    req_valid3 = '0; req_op3 = '0; req_sh3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;

    // Reset state
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_req_ready",  64'(req_ready),  64'h0);
    check("rst_rsp_valid",  64'(rsp_valid),  64'h0);
    check("rst_rsp_result", 64'(rsp_result), 64'h0);
    check("rst_alu_opcode", 64'(alu_op),     64'h0);
    check("rst_alu_a",      64'(alu_a),      64'h0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // 1: only req0 valid, OR
    set_lane(0, OP_OR, 5'd0, 32'hF0F0_0000, 32'h0000_0F0F);
    q.push_back('{id: 1'b0, res: 32'hF0F0_0F0F, ne: 1'b1, lt: 1'b1, ovf: 1'b0, err: 1'b0});
    req_valid = 2'b01;
    wait_ready(2'b01, "t1_ready", acc);
    req_valid = 2'b00;
    wait_rsp("t1_latency", acc, 2);
    tick(2);

    // 4: ALU_LATENCY = 3 instance, SLL 1 << 31
    req_op3[4:0] = OP_SLL; req_sh3[4:0] = 5'd31; req_a3[31:0] = 32'h1; req_b3[31:0] = 32'h0;
    req_valid3 = 2'b01;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req_ready3 != 2'b00) break;
    end
    check("t4_ready", 64'(req_ready3), 64'h1);
    acc = cyc;
    tick(1);
    req_valid3 = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid3) break;
    end
    check("t4_latency", 64'(cyc - acc), 64'd5);
    check("t4_result",  64'(rsp_result3), 64'h8000_0000);
    check("t4_id",      64'(rsp_id3),     64'h0);
    tick(2);

    // 2: both valid right after reset; req0 first, then req1
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    set_lane(0, OP_ADD, 5'd0, 32'd5, 32'd7);
    set_lane(1, OP_SUB, 5'd0, 32'd3, 32'd9);
    q.push_back('{id: 1'b0, res: 32'd12,        ne: 1'b1, lt: 1'b1, ovf: 1'b0, err: 1'b0});
    q.push_back('{id: 1'b1, res: 32'hFFFF_FFFA, ne: 1'b1, lt: 1'b1, ovf: 1'b0, err: 1'b0});
    req_valid = 2'b11;
    wait_ready(2'b01, "t2_first_grant", acc);
    req_valid = 2'b10;
    wait_ready(2'b10, "t2_second_grant", acc);
    req_valid = 2'b00;
    wait_rsp("t2_latency", acc, 2);
    tick(2);

    // 3: overflowing ADD with response stalled 4 cycles while req1 waits
    rsp_ready = 1'b0;
    set_lane(0, OP_ADD, 5'd0, 32'h7FFF_FFFF, 32'h1);
    q.push_back('{id: 1'b0, res: 32'h8000_0000, ne: 1'b1, lt: 1'b0, ovf: 1'b1, err: 1'b0});
    req_valid = 2'b01;
    wait_ready(2'b01, "t3_ready", acc);
    set_lane(1, OP_AND, 5'd0, 32'hFF00_FF00, 32'h0F0F_0F0F);
    q.push_back('{id: 1'b1, res: 32'h0F00_0F00, ne: 1'b1, lt: 1'b1, ovf: 1'b0, err: 1'b0});
    req_valid = 2'b10;
    wait_rsp("t3_latency", acc, 2);
    for (int i = 0; i < 4; i++) begin
      check("t3_stall_valid",  64'(rsp_valid),  64'h1);
      check("t3_stall_result", 64'(rsp_result), 64'h8000_0000);
      check("t3_stall_ovf",    64'(rsp_ovf),    64'h1);
      check("t3_stall_ready",  64'(req_ready),  64'h0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_ready(2'b10, "t3_grant_after_stall", acc);
    req_valid = 2'b00;
    wait_rsp("t3_req1_latency", acc, 2);
    tick(2);

    // 5: reset during EXEC drops the op and resets the pointer
    set_lane(0, OP_ADD, 5'd0, 32'd1, 32'd1);
    req_valid = 2'b01;
    wait_ready(2'b01, "t5_ready", acc);
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    check("t5_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    tick(1);
    set_lane(0, OP_SRA, 5'd4, 32'h8000_0000, 32'h0);
    set_lane(1, OP_SUB, 5'd0, 32'd10, 32'd10);
    q.push_back('{id: 1'b0, res: 32'hF800_0000, ne: 1'b1, lt: 1'b1, ovf: 1'b0, err: 1'b0});
    q.push_back('{id: 1'b1, res: 32'h0,         ne: 1'b0, lt: 1'b0, ovf: 1'b0, err: 1'b0});
    req_valid = 2'b11;
    @(negedge clk);
    check("t5_rst_req_ready", 64'(req_ready), 64'h0);
    check("t5_rst_rsp_valid2", 64'(rsp_valid), 64'h0);
    tick(1);
    rst = 1'b0;
    wait_ready(2'b01, "t5_grant_after_reset", acc);
    req_valid = 2'b10;
    wait_ready(2'b10, "t5_second_grant", acc);
    req_valid = 2'b00;
    wait_rsp("t5_latency", acc, 2);
    tick(2);

    // 6: illegal opcode from req1
`ifdef ALU_ARB_OPCODE_CHECK_EN
    lat6 = 1;
    q.push_back('{id: 1'b1, res: 32'h0, ne: 1'b0, lt: 1'b0, ovf: 1'b0, err: 1'b1});
`else
    lat6 = 2;
    q.push_back('{id: 1'b1, res: 32'h0, ne: 1'b0, lt: 1'b0, ovf: 1'b0, err: 1'b0});
`endif
    set_lane(1, 5'b11111, 5'd0, 32'h0, 32'h0);
    req_valid = 2'b10;
    wait_ready(2'b10, "t6_ready", acc);
    req_valid = 2'b00;
    wait_rsp("t6_latency", acc, lat6);
`ifdef ALU_ARB_OPCODE_CHECK_EN
    check("t6_alu_opcode_held", 64'(alu_op), 64'(OP_SUB));
`else
    check("t6_alu_opcode_fwd", 64'(alu_op), 64'h1F);
`endif
    tick(3);

    check("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
